data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single load/store port of data_mem (WDME/A/WD/RD) between NUM_REQ
//  requesters (compute cores / LSUs) using round-robin arbitration.
//  Each requester uses a valid/ready request and a one-cycle response pulse.
//  The block sequences exactly one word access at a time and flags misaligned
//  addresses. It sits between the core LSUs and data_mem; the AXI read port is untouched.
// PARAMETERS
//  NUM_REQ     4   number of requesters, >=2
//  DATA_WIDTH  32  word width, must match data_mem
//  ADDR_WIDTH  32  byte address width, must match data_mem
// PORTS
//  clk        in   1                   clock; all state updates on posedge
//  rst_n      in   1                   asynchronous reset, active-low
//  req_valid  in   NUM_REQ             per-requester request valid
//  req_we     in   NUM_REQ             1=store, 0=load
//  req_addr   in   NUM_REQ*ADDR_WIDTH  byte addresses, requester i in slice i
//  req_wdata  in   NUM_REQ*DATA_WIDTH  store data, requester i in slice i
//  req_ready  out  NUM_REQ             one-hot grant; the request is accepted on valid&ready
//  rsp_valid  out  NUM_REQ             one-hot, one-cycle completion pulse
//  rsp_rdata  out  DATA_WIDTH          load data; meaningful only while rsp_valid!=0
//  rsp_err    out  1                   misaligned access; qualified by rsp_valid
//  mem_we     out  1                   to data_mem WDME
//  mem_addr   out  ADDR_WIDTH          to data_mem A
//  mem_wdata  out  DATA_WIDTH          to data_mem WD
//  mem_rdata  in   DATA_WIDTH          from data_mem RD (combinational read)
//  busy       out  1                   high when state!=IDLE
// BEHAVIOUR
//  FSM has three states: IDLE, ACCESS, RESP.
//  IDLE:
//   - If any req_valid is high, rr_pick selects the first valid requester g.
//     The search starts at rr_ptr and wraps from NUM_REQ-1 to 0.
//   - req_ready[g]=1 combinationally in this same cycle.
//   - At the clock edge the block latches g, we, addr and wdata, then goes to ACCESS.
//   - req_ready is 0 in every state other than IDLE.
//  ACCESS (1 cycle):
//   - mem_addr = latched addr; mem_wdata = latched wdata.
//   - mem_we = latched we & aligned, where aligned = (addr[1:0]==0).
//   - rsp_rdata register <= mem_rdata and err register <= ~aligned, both at the edge.
//   - Next state is RESP.
//  RESP (1 cycle):
//   - rsp_valid[g]=1, rsp_err = err register.
//   - rsp_rdata holds the captured word, also for stores.
//   - rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1. Next state is IDLE.
//  Timing:
//   - Accept at cycle T, memory write edge ends cycle T+1, rsp_valid at T+2.
//   - Peak throughput is one access per 3 cycles.
//  Misaligned store: mem_we stays 0 and memory is unmodified; the response still completes with rsp_err=1.
//  Misaligned load: returns the word read at addr and sets rsp_err=1.
//  mem_we is 1 only in ACCESS. It is decoded from state and never depends on live req_* inputs.
//  Outside ACCESS, mem_addr and mem_wdata hold their last latched values.
//  Requesters must hold valid/we/addr/wdata until ready. Deasserting valid after accept has no effect.
//  Reset (async, any state):
//   - state=IDLE, rr_ptr=0, all latches=0.
//   - req_ready=0 while rst_n=0. rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
//   - An in-flight access is abandoned: no response, no write.
//  With a single active requester, that requester is regranted every 3 cycles.
//  With all requesters active, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ grants.
// STRUCTURE
//  Package data_mem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t
//   - localparam ARB_RSP_LATENCY = 2
//  Sub-module rr_pick:
//   - combinational, ports valid[NUM_REQ] and ptr -> grant one-hot, idx, any.
//   - Also reusable for other shared resources.
// TESTING
//  1. Reset: hold rst_n=0 with req_valid=4'hF -> req_ready=0, mem_we=0, busy=0.
//  2. Store then load, requester 0:
//     - Store addr=0x100, wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle, rsp_valid=4'b0001 two cycles after accept, rsp_err=0.
//     - Load addr=0x100 -> rsp_rdata=0xDEADBEEF.
//  3. All four requesters load together:
//     - Requester i loads addr=0x10*i after preloading distinct words.
//     - Grant order must be 0,1,2,3, each with the matching rsp_rdata, responses 3 cycles apart.
//  4. Fairness: req0 and req2 always valid -> grants alternate 0,2,0,2, and requester 0 never gets two grants in a row.
//  5. Misaligned store addr=0x102 -> mem_we stays 0, rsp_err=1, and a later load of 0x100 returns the prior value.
//  6. Reset mid-op: assert rst_n=0 during ACCESS of a store -> no rsp_valid, rr_ptr=0, and after release requester 0 is granted first.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data_mem load/store port arbiter.
// Imported by the arbiter top, its interface users and the bench.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Cycles from the accepting edge's cycle to the rsp_valid cycle.
  localparam int ARB_RSP_LATENCY = 2;

  function automatic logic is_aligned(input logic [1:0] byte_lsbs);
    return (byte_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the requester-side handshake and the data_mem word port.
// slave = the arbiter's view, master = the requesters' and memory's view.
interface data_mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  // Handshake: requester i holds req_valid[i] and its we/addr/wdata slices
  // stable until it sees req_ready[i]; the request is taken at the clock
  // edge where req_valid[i] & req_ready[i]. Completion is a single-cycle
  // rsp_valid[i] pulse carrying rsp_rdata/rsp_err; there is no back-pressure.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/data_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or after ptr,
// wrapping from N-1 back to 0. Usable for any shared resource.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = cand[IW-1:0];
      if (!any && valid[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing data_mem's single word port (WDME/A/WD/RD)
// among NUM_REQ requesters; one access in flight, flags misaligned addresses.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_arbiter_if.slave    bus,
  output arb_state_t           dbg_state,
  output logic [PW-1:0]        dbg_rr_ptr
);

  arb_state_t             state_q,   state_d;
  logic [PW-1:0]          rr_ptr_q,  rr_ptr_d;
  logic [PW-1:0]          gnt_idx_q, gnt_idx_d;
  logic                   we_q,      we_d;
  logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q,   wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q,   rdata_d;
  logic                   err_q,     err_d;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [PW-1:0]          pick_idx;
  logic                   pick_any;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   aligned;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic                   mem_we;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Steer the winning requester's fields; constant indices keep this a plain mux.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign aligned = is_aligned(addr_q[1:0]);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gate with rst_n so nothing looks accepted while reset is held.
        if (pick_any && rst_n) begin
          req_ready = pick_grant;
          gnt_idx_d = pick_idx;
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Misaligned stores are suppressed; the read still happens.
        mem_we  = we_q & aligned;
        rdata_d = bus.mem_rdata;
        err_d   = ~aligned;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[gnt_idx_q] = 1'b1;
        rr_ptr_d = (gnt_idx_q == PW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + PW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = (state_q == RESP) ? err_q : 1'b0;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state     = state_q;
  assign dbg_rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a word memory behind the port, a transaction
// model checked on every falling edge, and directed scenarios with literal checks.
module tb_data_mem_arbiter;
  import data_mem_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  arb_state_t dbg_state;
  logic [1:0] dbg_rr_ptr;

  data_mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- requester inputs ----------------
  logic          v [N];
  logic          w [N];
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]             = v[i];
      bus.req_we[i]                = w[i];
      bus.req_addr[i*AW +: AW]     = a[i];
      bus.req_wdata[i*DW +: DW]    = d[i];
    end
  end

  // ---------------- data_mem stand-in ----------------
  logic [DW-1:0] tb_mem  [256] = '{default: '0};
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  logic          pl_en   = 1'b0;
  logic [7:0]    pl_idx  = '0;
  logic [DW-1:0] pl_data = '0;

  assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_idx] <= pl_data;
    else if (bus.mem_we) tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction model / scoreboard ----------------
  int            cyc = 0;
  int            phase = 0;        // 0 waiting, 1 memory cycle, 2 response cycle
  int            m_ptr = 0;
  int            m_g = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_err = 1'b0;
  int            we_pulses = 0;
  int            mc;
  logic          found;
  logic [N-1:0]  exp_ready;
  logic [DW-1:0] exp_q [$];

  int            grant_log [$];
  int            gcyc_log  [$];
  int            rsp_g_log [$];
  int            rsp_cyc_log [$];
  logic [DW-1:0] rsp_d_log [$];
  logic          rsp_e_log [$];

  task automatic clear_logs();
    grant_log.delete(); gcyc_log.delete(); rsp_g_log.delete();
    rsp_cyc_log.delete(); rsp_d_log.delete(); rsp_e_log.delete();
    we_pulses = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_we) we_pulses++;
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, '0);
      chk("rst_rsp_valid", bus.rsp_valid, '0);
      chk("rst_mem_we",    bus.mem_we, 1'b0);
      chk("rst_busy",      bus.busy, 1'b0);
      chk("rst_rsp_err",   bus.rsp_err, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, '0);
      chk("rst_mem_addr",  bus.mem_addr, '0);
      chk("rst_mem_wdata", bus.mem_wdata, '0);
      chk("rst_rr_ptr",    dbg_rr_ptr, '0);
      phase = 0; m_ptr = 0; m_g = 0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      case (phase)
        0: begin
          found = 1'b0;
          exp_ready = '0;
          for (int k = 0; k < N; k++) begin
            mc = (m_ptr + k) % N;
            if (!found && v[mc]) begin
              found = 1'b1;
              m_g = mc;
            end
          end
          if (found) exp_ready[m_g] = 1'b1;
          chk("idle_req_ready", bus.req_ready, exp_ready);
          chk("idle_busy",      bus.busy, 1'b0);
          chk("idle_rsp_valid", bus.rsp_valid, '0);
          chk("idle_mem_we",    bus.mem_we, 1'b0);
          chk("idle_mem_addr",  bus.mem_addr, m_addr);
          chk("idle_mem_wdata", bus.mem_wdata, m_wdata);
          if (found) begin
            m_we = w[m_g]; m_addr = a[m_g]; m_wdata = d[m_g];
            grant_log.push_back(m_g);
            gcyc_log.push_back(cyc);
            phase = 1;
          end
        end
        1: begin
          chk("acc_busy",      bus.busy, 1'b1);
          chk("acc_req_ready", bus.req_ready, '0);
          chk("acc_rsp_valid", bus.rsp_valid, '0);
          chk("acc_mem_we",    bus.mem_we, m_we && (m_addr[1:0] == 2'b00));
          chk("acc_mem_addr",  bus.mem_addr, m_addr);
          chk("acc_mem_wdata", bus.mem_wdata, m_wdata);
          exp_q.push_back(ref_mem[m_addr[9:2]]);
          m_err = (m_addr[1:0] != 2'b00);
          if (m_we && !m_err) ref_mem[m_addr[9:2]] = m_wdata;
          phase = 2;
        end
        default: begin
          exp_ready = '0;
          exp_ready[m_g] = 1'b1;
          chk("rsp_busy",      bus.busy, 1'b1);
          chk("rsp_req_ready", bus.req_ready, '0);
          chk("rsp_valid",     bus.rsp_valid, exp_ready);
          chk("rsp_mem_we",    bus.mem_we, 1'b0);
          chk("rsp_mem_addr",  bus.mem_addr, m_addr);
          chk("rsp_rdata",     bus.rsp_rdata, exp_q.pop_front());
          chk("rsp_err",       bus.rsp_err, m_err);
          rsp_g_log.push_back(m_g);
          rsp_cyc_log.push_back(cyc);
          rsp_d_log.push_back(bus.rsp_rdata);
          rsp_e_log.push_back(bus.rsp_err);
          m_ptr = (m_g + 1) % N;
          phase = 0;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic req(input int i, input logic we_i, input logic [AW-1:0] ad,
                     input logic [DW-1:0] wd);
    int n = 0;
    v[i] = 1'b1; w[i] = we_i; a[i] = ad; d[i] = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready[i] && n < 50);
    chk($sformatf("accept_req%0d", i), bus.req_ready[i], 1'b1);
    @(posedge clk);
    #1;
    v[i] = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    ref_mem[ad[9:2]] = wd;
    pl_en = 1'b1; pl_idx = ad[9:2]; pl_data = wd;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; w[i] = 1'b0; a[i] = '0; d[i] = '0;
    end

    // Reset held with every requester asking
    repeat (3) @(posedge clk);
    #1;
    chk("t1_ready", bus.req_ready, '0);
    chk("t1_mem_we", bus.mem_we, 1'b0);
    chk("t1_busy", bus.busy, 1'b0);
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();

    // Store then load, requester 0
    clear_logs();
    req(0, 1'b1, 32'h100, 32'hDEADBEEF);
    settle();
    chk("t2_we_pulses", we_pulses, 1);
    chk("t2_grant", grant_log[0], 0);
    chk("t2_latency", rsp_cyc_log[0] - gcyc_log[0], ARB_RSP_LATENCY);
    chk("t2_store_err", rsp_e_log[0], 1'b0);
    chk("t2_store_rdata_old", rsp_d_log[0], 32'h0);
    clear_logs();
    req(0, 1'b0, 32'h100, '0);
    settle();
    chk("t2_load_rdata", rsp_d_log[0], 32'hDEADBEEF);
    chk("t2_load_we_pulses", we_pulses, 0);

    // Pointer now at 1: a lone requester 3 must still win, wrapping it to 0
    preload(32'h00, 32'h11111111);
    preload(32'h10, 32'h22222222);
    preload(32'h20, 32'h33333333);
    preload(32'h30, 32'h44444444);
    clear_logs();
    req(3, 1'b0, 32'h30, '0);
    settle();
    chk("t3_wrap_grant", grant_log[0], 3);
    chk("t3_wrap_rdata", rsp_d_log[0], 32'h44444444);

    // All four load together
    clear_logs();
    fork
      req(0, 1'b0, 32'h00, '0);
      req(1, 1'b0, 32'h10, '0);
      req(2, 1'b0, 32'h20, '0);
      req(3, 1'b0, 32'h30, '0);
    join
    settle();
    chk("t3_n_rsp", rsp_g_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_grant%0d", i), grant_log[i], i);
      chk($sformatf("t3_rsp_g%0d", i), rsp_g_log[i], i);
    end
    chk("t3_rdata0", rsp_d_log[0], 32'h11111111);
    chk("t3_rdata1", rsp_d_log[1], 32'h22222222);
    chk("t3_rdata2", rsp_d_log[2], 32'h33333333);
    chk("t3_rdata3", rsp_d_log[3], 32'h44444444);
    for (int i = 1; i < 4; i++)
      chk($sformatf("t3_spacing%0d", i), rsp_cyc_log[i] - rsp_cyc_log[i-1], 3);

    // Fairness between requesters 0 and 2
    clear_logs();
    fork
      begin repeat (4) req(0, 1'b0, 32'h00, '0); end
      begin repeat (4) req(2, 1'b0, 32'h20, '0); end
    join
    settle();
    chk("t4_n_grants", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t4_grant%0d", i), grant_log[i], (i % 2 == 0) ? 0 : 2);
    for (int i = 1; i < 8; i++)
      if (grant_log[i] == 0)
        chk($sformatf("t4_no_repeat%0d", i), grant_log[i-1], 2);

    // Misaligned store and load
    clear_logs();
    req(1, 1'b1, 32'h102, 32'hCAFEF00D);
    settle();
    chk("t5_grant", grant_log[0], 1);
    chk("t5_we_pulses", we_pulses, 0);
    chk("t5_err", rsp_e_log[0], 1'b1);
    chk("t5_store_rdata", rsp_d_log[0], 32'hDEADBEEF);
    clear_logs();
    req(0, 1'b0, 32'h100, '0);
    req(2, 1'b0, 32'h103, '0);
    settle();
    chk("t5_reload", rsp_d_log[0], 32'hDEADBEEF);
    chk("t5_reload_err", rsp_e_log[0], 1'b0);
    chk("t5_mis_load", rsp_d_log[1], 32'hDEADBEEF);
    chk("t5_mis_load_err", rsp_e_log[1], 1'b1);

    // Reset during a store's memory cycle
    clear_logs();
    req(1, 1'b0, 32'h10, '0);
    settle();
    clear_logs();
    req(2, 1'b1, 32'h200, 32'h00000055);
    chk("t6_in_access", dbg_state, ACCESS);
    rst_n = 1'b0;
    #1;
    chk("t6_we_killed", bus.mem_we, 1'b0);
    chk("t6_ptr_reset", dbg_rr_ptr, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle();
    chk("t6_no_rsp", rsp_g_log.size(), 0);
    chk("t6_no_write", we_pulses, 0);
    clear_logs();
    fork
      req(0, 1'b0, 32'h100, '0);
      req(2, 1'b0, 32'h200, '0);
    join
    settle();
    chk("t6_first_grant", grant_log[0], 0);
    chk("t6_second_grant", grant_log[1], 2);
    chk("t6_mem_untouched", rsp_d_log[1], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
